sdram_arbit: RTL and testbench
==============================

// Module: sdram_arbit
// PURPOSE
// Command arbiter between the SDRAM sub-controllers (sdram_init, sdram_aref, sdram_write, sdram_read) and the SDRAM pins.
// Passes init commands through until init_end, then grants one of refresh / write / read at a time.
// Muxes the granted stage's cmd/ba/addr onto the bus and drives the tri-state DQ during writes.
// Sits between the stage modules and the device; replaces ad-hoc init/aref muxing at top level.
// PARAMETERS
// DATA_W   16          SDRAM DQ width
// ADDR_W   13          SDRAM address width
// CMD_NOP  4'b0111     {cs_n,ras_n,cas_n,we_n} NOP code driven in ARBIT
// PORTS
// clk_100m      in   1       controller clock
// rst_n         in   1       async active-low reset
// init_cmd/ba/addr  in  4/2/ADDR_W  init stage command bus
// init_end      in   1       init complete (level, stays high)
// aref_req      in   1       refresh request (level, held until granted)
// aref_cmd/ba/addr  in  4/2/ADDR_W  refresh stage command bus
// aref_end      in   1       refresh burst done (1-cycle pulse)
// wr_req        in   1       write request (level)
// wr_cmd/ba/addr    in  4/2/ADDR_W  write stage command bus
// wr_end        in   1       write done (pulse)
// wr_sdram_en   in   1       write stage drives DQ this cycle
// wr_sdram_data in   DATA_W  write data
// rd_req        in   1       read request (level)
// rd_cmd/ba/addr    in  4/2/ADDR_W  read stage command bus
// rd_end        in   1       read done (pulse)
// aref_en       out  1       refresh grant (registered)
// wr_en         out  1       write grant (registered)
// rd_en         out  1       read grant (registered)
// sdram_cke     out  1       constant 1
// sdram_cs_n/ras_n/cas_n/we_n  out  1 each  = selected cmd[3]/[2]/[1]/[0]
// sdram_ba      out  2       selected bank
// sdram_addr    out  ADDR_W  selected address
// sdram_dq      inout DATA_W  wr_sdram_en ? wr_sdram_data : 'z
// BEHAVIOUR
// - FSM states: IDLE, ARBIT, AREF, WRITE, READ; one-hot or binary, registered on clk_100m.
// - Reset: state=IDLE; aref_en=wr_en=rd_en=0; bus outputs follow init_* (comb mux); sdram_dq='z.
// - IDLE -> ARBIT when init_end=1; the IDLE bus equals init_cmd/ba/addr.
// - ARBIT: fixed priority aref_req > wr_req > rd_req; go to AREF/WRITE/READ next cycle; else stay.
//   ARBIT bus: cmd=CMD_NOP, ba=2'b11, addr=all ones.
// - AREF/WRITE/READ: bus = that stage's cmd/ba/addr; on its *_end -> ARBIT next cycle.
// - Grant: x_en <= 1 on the same edge state enters X; x_en <= 0 on the edge that leaves X.
//   x_en == (state==X) at all times; at most one grant high.
// - Min turnaround: *_end at cycle N -> state ARBIT at N+1 -> new grant at N+2.
// - Requests arriving while busy wait; never preempt; no request is dropped.
// - *_end pulse from a non-granted stage: ignored.
// - Simultaneous aref_req & wr_req & rd_req in ARBIT: AREF wins; write next, then read.
// - init_end dropping after ARBIT entry: ignored (no return to IDLE except via reset).
// - Reset mid-operation: immediate IDLE, grants 0, DQ released same cycle (async).
// - Output mux is combinational from the state register; no added latency on cmd path.
// TESTING
// 1 Reset then init_end rises at t0 -> ARBIT at t0+1, sdram cmd = init_cmd until then, 4'b0111 after.
// 2 aref_req=1 in ARBIT -> aref_en=1 next edge, cmd follows aref_cmd; aref_end pulse -> aref_en=0 next edge.
// 3 aref_req, wr_req, rd_req all high together -> grant order AREF, WRITE, READ, each after prior *_end.
// 4 WRITE grant, wr_sdram_en=1, data 16'hA5A5 -> sdram_dq=16'hA5A5; en=0 -> dq='z.
// 5 rd_end pulsed while in WRITE -> no state change; wr_end -> ARBIT.
// 6 rst_n low during READ -> rd_en=0 and dq='z immediately, state IDLE; recover after init_end.

Source files
------------

// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM pins to init, then to one of refresh/write/read at a time
module sdram_arbit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 13,
    parameter logic [3:0]  CMD_NOP = 4'b0111
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic [3:0]        init_cmd_i,
    input  logic [1:0]        init_ba_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic              init_end_i,
    input  logic              aref_req_i,
    input  logic [3:0]        aref_cmd_i,
    input  logic [1:0]        aref_ba_i,
    input  logic [ADDR_W-1:0] aref_addr_i,
    input  logic              aref_end_i,
    input  logic              wr_req_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [1:0]        wr_ba_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              wr_end_i,
    input  logic              wr_sdram_en_i,
    input  logic [DATA_W-1:0] wr_sdram_data_i,
    input  logic              rd_req_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [1:0]        rd_ba_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_end_i,
    output logic              aref_en_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic              sdram_cke_o,
    output logic              sdram_cs_n_o,
    output logic              sdram_ras_n_o,
    output logic              sdram_cas_n_o,
    output logic              sdram_we_n_o,
    output logic [1:0]        sdram_ba_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    inout  wire  [DATA_W-1:0] sdram_dq_io
);

    typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;

    state_t            state_q, state_d;
    logic              aref_en_q, wr_en_q, rd_en_q;
    logic [3:0]        cmd;
    logic [1:0]        ba;
    logic [ADDR_W-1:0] addr;

    // Next state: fixed priority refresh > write > read, no preemption, foreign *_end ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = init_end_i ? ARBIT : IDLE;
            ARBIT:   state_d = aref_req_i ? AREF : wr_req_i ? WRITE : rd_req_i ? READ : ARBIT;
            AREF:    state_d = aref_end_i ? ARBIT : AREF;
            WRITE:   state_d = wr_end_i ? ARBIT : WRITE;
            READ:    state_d = rd_end_i ? ARBIT : READ;
            default: state_d = IDLE;
        endcase
    end

    // State and grants register together so each grant tracks its state exactly
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= state_d == AREF;
            wr_en_q   <= state_d == WRITE;
            rd_en_q   <= state_d == READ;
        end
    end

    // Command bus mux straight off the state register, no extra latency
    always_comb begin
        cmd  = CMD_NOP;
        ba   = 2'b11;
        addr = '1;
        case (state_q)
            IDLE:  {cmd, ba, addr} = {init_cmd_i, init_ba_i, init_addr_i};
            AREF:  {cmd, ba, addr} = {aref_cmd_i, aref_ba_i, aref_addr_i};
            WRITE: {cmd, ba, addr} = {wr_cmd_i, wr_ba_i, wr_addr_i};
            READ:  {cmd, ba, addr} = {rd_cmd_i, rd_ba_i, rd_addr_i};
            default: ;
        endcase
    end

    assign aref_en_o     = aref_en_q;
    assign wr_en_o       = wr_en_q;
    assign rd_en_o       = rd_en_q;
    assign sdram_cke_o   = 1'b1;
    assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = cmd;
    assign sdram_ba_o    = ba;
    assign sdram_addr_o  = addr;

    // Reset releases DQ without waiting for a clock edge
    assign sdram_dq_io = (rst_n && wr_sdram_en_i) ? wr_sdram_data_i : 'z;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scoreboard bench for the SDRAM command arbiter
module tb_sdram_arbit;

    typedef enum {S_IDLE, S_ARBIT, S_AREF, S_WRITE, S_READ} st_t;
    typedef struct {string tag; st_t st;} exp_t;

    logic        clk_100m = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  init_cmd = 4'b0001, aref_cmd = 4'b0010, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
    logic [1:0]  init_ba = 2'b01, aref_ba = 2'b10, wr_ba = 2'b00, rd_ba = 2'b01;
    logic [12:0] init_addr = 13'h0123, aref_addr = 13'h0456, wr_addr = 13'h0789, rd_addr = 13'h0ABC;
    logic        init_end = 0, aref_req = 0, aref_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
    logic        wr_sdram_en = 0;
    logic [15:0] wr_sdram_data = 16'h0000;
    logic        tb_dq_en = 0;
    logic [15:0] tb_dq = 16'h5A5A;
    logic        aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    wire  [15:0] sdram_dq;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    assign sdram_dq = tb_dq_en ? tb_dq : 'z;

    always #5 clk_100m = ~clk_100m;

    sdram_arbit dut (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .init_cmd_i(init_cmd), .init_ba_i(init_ba), .init_addr_i(init_addr), .init_end_i(init_end),
        .aref_req_i(aref_req), .aref_cmd_i(aref_cmd), .aref_ba_i(aref_ba), .aref_addr_i(aref_addr),
        .aref_end_i(aref_end),
        .wr_req_i(wr_req), .wr_cmd_i(wr_cmd), .wr_ba_i(wr_ba), .wr_addr_i(wr_addr), .wr_end_i(wr_end),
        .wr_sdram_en_i(wr_sdram_en), .wr_sdram_data_i(wr_sdram_data),
        .rd_req_i(rd_req), .rd_cmd_i(rd_cmd), .rd_ba_i(rd_ba), .rd_addr_i(rd_addr), .rd_end_i(rd_end),
        .aref_en_o(aref_en), .wr_en_o(wr_en), .rd_en_o(rd_en), .sdram_cke_o(cke),
        .sdram_cs_n_o(cs_n), .sdram_ras_n_o(ras_n), .sdram_cas_n_o(cas_n), .sdram_we_n_o(we_n),
        .sdram_ba_o(ba), .sdram_addr_o(addr), .sdram_dq_io(sdram_dq)
    );

    // Expected pin picture for a given arbiter state: {cke, grants, cmd, ba, addr}
    function automatic logic [23:0] model(st_t s);
        logic [3:0]  c;
        logic [1:0]  b;
        logic [12:0] a;
        case (s)
            S_IDLE:  {c, b, a} = {init_cmd, init_ba, init_addr};
            S_AREF:  {c, b, a} = {aref_cmd, aref_ba, aref_addr};
            S_WRITE: {c, b, a} = {wr_cmd, wr_ba, wr_addr};
            S_READ:  {c, b, a} = {rd_cmd, rd_ba, rd_addr};
            default: {c, b, a} = {4'b0111, 2'b11, 13'h1FFF};
        endcase
        return {1'b1, s == S_AREF, s == S_WRITE, s == S_READ, c, b, a};
    endfunction

    function automatic logic [23:0] observed();
        return {cke, aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, ba, addr};
    endfunction

    task automatic drain();
        exp_t e;
        logic [23:0] o, m;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = observed();
            m = model(e.st);
            n_cmp++;
            assert (o === m) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, m);
            end
        end
    endtask

    // Expect state s after the next rising edge
    task automatic step(string tag, st_t s);
        q.push_back('{tag, s});
        @(posedge clk_100m);
        #1;
        drain();
    endtask

    // Expect state s right now, without a clock edge
    task automatic now(string tag, st_t s);
        q.push_back('{tag, s});
        #1;
        drain();
    endtask

    task automatic chk_dq(string tag, logic [15:0] exp);
        n_cmp++;
        assert (sdram_dq === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, sdram_dq, exp);
        end
    endtask

    initial begin
        #2;
        now("reset_idle", S_IDLE);
        tb_dq_en = 1'b1;
        #1 chk_dq("reset_dq_released", 16'h5A5A);
        tb_dq_en = 1'b0;
        @(negedge clk_100m) rst_n = 1'b1;
        step("idle_wait_init", S_IDLE);
        init_cmd = 4'b1000;
        init_addr = 13'h1555;
        now("idle_follows_init", S_IDLE);
        init_end = 1'b1;
        now("init_end_same_cycle", S_IDLE);
        step("init_to_arbit", S_ARBIT);
        init_end = 1'b0;
        step("init_drop_ignored", S_ARBIT);
        // refresh grant and release
        aref_req = 1'b1;
        now("arbit_nop_before_grant", S_ARBIT);
        step("aref_grant", S_AREF);
        aref_req = 1'b0;
        aref_addr = 13'h0EEE;
        step("aref_hold", S_AREF);
        aref_end = 1'b1;
        step("aref_end_to_arbit", S_ARBIT);
        aref_end = 1'b0;
        step("arbit_idle_stays", S_ARBIT);
        // all three together: AREF, then WRITE, then READ
        {aref_req, wr_req, rd_req} = 3'b111;
        step("prio_aref_first", S_AREF);
        aref_req = 1'b0;
        step("aref_no_preempt", S_AREF);
        aref_end = 1'b1;
        step("aref_done", S_ARBIT);
        aref_end = 1'b0;
        step("prio_write_second", S_WRITE);
        wr_req = 1'b0;
        // DQ driven only while the write stage enables it
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'hA5A5;
        #1 chk_dq("dq_driven", 16'hA5A5);
        wr_sdram_en = 1'b0;
        tb_dq_en = 1'b1;
        #1 chk_dq("dq_released", 16'h5A5A);
        tb_dq_en = 1'b0;
        // foreign end pulses ignored during WRITE
        rd_end = 1'b1;
        aref_end = 1'b1;
        step("foreign_end_ignored", S_WRITE);
        {rd_end, aref_end} = 2'b00;
        wr_end = 1'b1;
        step("wr_end_to_arbit", S_ARBIT);
        wr_end = 1'b0;
        step("prio_read_third", S_READ);
        rd_req = 1'b0;
        wr_end = 1'b1;
        step("wr_end_in_read_ignored", S_READ);
        wr_end = 1'b0;
        rd_end = 1'b1;
        step("rd_end_to_arbit", S_ARBIT);
        rd_end = 1'b0;
        // write beats read when both wait
        {wr_req, rd_req} = 2'b11;
        step("write_over_read", S_WRITE);
        wr_req = 1'b0;
        wr_end = 1'b1;
        step("write_done", S_ARBIT);
        wr_end = 1'b0;
        step("pending_read_served", S_READ);
        rd_req = 1'b0;
        // async reset during READ with DQ driven
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'h1234;
        #1 chk_dq("dq_before_reset", 16'h1234);
        rst_n = 1'b0;
        now("reset_mid_read", S_IDLE);
        tb_dq_en = 1'b1;
        #1 chk_dq("reset_dq_release", 16'h5A5A);
        tb_dq_en = 1'b0;
        wr_sdram_en = 1'b0;
        @(negedge clk_100m) rst_n = 1'b1;
        step("post_reset_idle", S_IDLE);
        init_end = 1'b1;
        step("recover_arbit", S_ARBIT);
        rd_req = 1'b1;
        step("recover_read", S_READ);
        rd_req = 1'b0;
        step("final_read_hold", S_READ);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
